// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI main-side transfer engine.
package spi_pkg;

  // Default transfer width in bits.
  localparam int unsigned SPI_DATA_WIDTH = 8;

  // Only mode 0 is implemented: sclk idles low and data is sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  // Main transfer FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } main_state_e;

  // Operating modes of universal_shift_reg.
  typedef enum logic [1:0] {
    UsrHold = 2'd0,
    UsrShl  = 2'd1,
    UsrShr  = 2'd2,
    UsrLoad = 2'd3
  } usr_mode_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period divider and sclk toggle. A phase event fires every div+1 cycles while
// enabled; the clock only toggles on events where toggle_en is set, so the caller can
// spend whole half-periods with sclk parked at its idle level.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 toggle_en,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 phase_evt,
  output logic                 rise_evt,
  output logic                 fall_evt,
  output logic                 sclk
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic                 sclk_q;

  assign phase_evt = en && (cnt_q == div);
  assign rise_evt  = phase_evt && toggle_en && (sclk_q == SPI_CPOL);
  assign fall_evt  = phase_evt && toggle_en && (sclk_q != SPI_CPOL);
  assign sclk      = sclk_q;

  // Half-period counter: 0..div, wraps on each phase event; div = all-ones is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || phase_evt) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Serial clock: parked at idle level when disabled, toggles on enabled phase events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= SPI_CPOL;
    end else if (!en) begin
      sclk_q <= SPI_CPOL;
    end else if (phase_evt && toggle_en) begin
      sclk_q <= ~sclk_q;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift left, shift right or parallel load.
module universal_shift_reg
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  usr_mode_e        mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             shl_in,  // enters at bit 0 on a left shift
  input  logic             shr_in,  // enters at bit WIDTH-1 on a right shift
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  // Register update selected by mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      case (mode)
        UsrLoad: q_q <= par_in;
        UsrShl:  q_q <= {q_q[WIDTH-2:0], shl_in};
        UsrShr:  q_q <= {shr_in, q_q[WIDTH-1:1]};
        default: q_q <= q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/main_shift_ctrl_block.sv
// SPI main-side transfer engine (mode 0). Accepts one word over a valid/ready
// handshake, frames it with ss/sclk, shifts it out on mosi and captures miso.
// Build option: define SPI_MAIN_LSB_FIRST_EN to send and receive LSB first.
module main_shift_ctrl_block
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  ss_pad_o,
  output logic                  sclk_pad_o,
  output logic                  mosi_pad_o,
  input  logic                  miso_pad_i
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH);

  main_state_e           state_q, state_d;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [DATA_WIDTH-1:0] tx_q, rx_q, rx_data_q;
  logic                  rx_valid_q;
  logic                  accept, active, done_entry, last_low;
  logic                  phase_evt, rise_evt, fall_evt, sample_evt, sclk;
  logic                  toggle_en, tx_bit;
  usr_mode_e             tx_mode, rx_mode;

`ifdef SPI_MAIN_LSB_FIRST_EN
  localparam usr_mode_e ShiftMode = UsrShr;
  assign tx_bit = tx_q[0];
`else
  localparam usr_mode_e ShiftMode = UsrShl;
  assign tx_bit = tx_q[DATA_WIDTH-1];
`endif

  assign accept     = tx_valid && (state_q == IDLE);
  assign active     = (state_q == SETUP) || (state_q == SHIFT);
  // All bits exchanged and sclk back low: the final low half-period is in progress.
  assign last_low   = (bit_cnt_q == LastBit) && !sclk;
  assign done_entry = (state_q == SHIFT) && (state_d == DONE);
  // Sampling edge follows the clock phase; only CPHA=0 is supported.
  assign sample_evt = SPI_CPHA ? fall_evt : rise_evt;
  assign toggle_en  = (state_q == SETUP) || ((state_q == SHIFT) && !last_low);

  // Next-state logic; every non-IDLE state advances on a divider phase event.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (phase_evt) state_d = SHIFT;
      SHIFT:   if (phase_evt && last_low) state_d = DONE;
      DONE:    if (phase_evt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift-register controls; the last falling edge does not shift so mosi holds.
  always_comb begin
    tx_mode = UsrHold;
    rx_mode = UsrHold;
    if (accept) begin
      tx_mode = UsrLoad;
      rx_mode = UsrLoad;
    end else begin
      if ((state_q == SHIFT) && fall_evt && (bit_cnt_q != LastBit)) tx_mode = ShiftMode;
      if (sample_evt) rx_mode = ShiftMode;
    end
  end

  // State, latched divider and bit counter.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        div_q     <= clk_div;
        bit_cnt_q <= '0;
      end else if (sample_evt) begin
        bit_cnt_q <= bit_cnt_q + CntW'(1);
      end
    end
  end

  // Received word is published on entry to DONE with a one-cycle strobe.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= done_entry;
      if (done_entry) rx_data_q <= rx_q;
    end
  end

  spi_sclk_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_sclk_gen (
    .clk       (pclk),
    .rst_n     (presetn),
    .en        (state_q != IDLE),
    .toggle_en (toggle_en),
    .div       (div_q),
    .phase_evt (phase_evt),
    .rise_evt  (rise_evt),
    .fall_evt  (fall_evt),
    .sclk      (sclk)
  );

  universal_shift_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_tx_sr (
    .clk    (pclk),
    .rst_n  (presetn),
    .mode   (tx_mode),
    .par_in (tx_data),
    .shl_in (1'b0),
    .shr_in (1'b0),
    .q      (tx_q)
  );

  universal_shift_reg #(
    .WIDTH(DATA_WIDTH)
  ) u_rx_sr (
    .clk    (pclk),
    .rst_n  (presetn),
    .mode   (rx_mode),
    .par_in ('0),
    .shl_in (miso_pad_i),
    .shr_in (miso_pad_i),
    .q      (rx_q)
  );

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign ss_pad_o   = !active;
  assign sclk_pad_o = sclk;
  assign mosi_pad_o = active && tx_bit;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;

endmodule

// File: tb/tb_main_shift_ctrl_block.sv
// Directed bench for main_shift_ctrl_block: table of single transfers plus
// hand-written reset, back-to-back and reset-recovery sequences.
module tb_main_shift_ctrl_block;

`ifdef SPI_MAIN_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  localparam int N = 8;

  logic       pclk, presetn;
  logic [7:0] clk_div, tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, busy, ss, sclk, mosi, miso;

  // Sub-side model: loopback, or a fixed word sent one bit per rising edge.
  logic       loop_mode;
  logic [7:0] sub_word;
  int         rcnt;

  int total, bad;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] div;
    bit         loop;
    logic [7:0] sub;
    bit         chg;
    logic [7:0] div2;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[6];

  main_shift_ctrl_block dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .clk_div    (clk_div),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .ss_pad_o   (ss),
    .sclk_pad_o (sclk),
    .mosi_pad_o (mosi),
    .miso_pad_i (miso)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always_comb begin
    miso = 1'b0;
    if (loop_mode) miso = mosi;
    else if (rcnt >= 0 && rcnt < N) miso = LSB ? sub_word[rcnt] : sub_word[N-1-rcnt];
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One complete transfer with timing, waveform and data checks.
  task automatic run_xfer(input vec_t v, input string nm);
    int c, rv_cyc, rv_cnt, tr_cyc, rises, hi_run, bad_width, bad_mosi, ss_hi;
    logic [7:0] rxs;
    logic prev_sclk, expb;
    int dd;
    dd = int'(v.div) + 1;
    loop_mode = v.loop;
    sub_word  = v.sub;
    rcnt = 0;
    c = 0;
    while (!tx_ready && c < 100) begin
      @(negedge pclk);
      c++;
    end
    tx_data  = v.tx;
    clk_div  = v.div;
    tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    tx_data  = ~v.tx;  // must be ignored after acceptance
    c = 1;
    rv_cyc = -1; tr_cyc = -1; rv_cnt = 0; rises = 0; hi_run = 0;
    bad_width = 0; bad_mosi = 0; ss_hi = 0; rxs = '0; prev_sclk = 1'b0;
    while (tr_cyc < 0 && c < 20000) begin
      if (v.chg && c == 5) clk_div = v.div2;
      if (rx_valid) begin
        rv_cnt++;
        rv_cyc = c;
        rxs = rx_data;
      end
      if (sclk && !prev_sclk) begin
        expb = LSB ? v.tx[rises % N] : v.tx[N-1-(rises % N)];
        if (mosi !== expb) bad_mosi++;
        if (ss) ss_hi++;
        rises++;
        rcnt++;
        hi_run = 0;
      end
      if (sclk) hi_run++;
      if (!sclk && prev_sclk && hi_run != dd) bad_width++;
      if (tx_ready) tr_cyc = c;
      prev_sclk = sclk;
      if (tr_cyc < 0) begin
        @(negedge pclk);
        c++;
      end
    end
    check({nm, " rx_valid_cycle"}, rv_cyc, (2 * N + 1) * dd + 1);
    check({nm, " rx_valid_count"}, rv_cnt, 1);
    check({nm, " rx_data"}, int'(rxs), int'(v.exp_rx));
    check({nm, " tx_ready_cycle"}, tr_cyc, (2 * N + 2) * dd + 1);
    check({nm, " rise_count"}, rises, N);
    check({nm, " mosi_bits_wrong"}, bad_mosi, 0);
    check({nm, " sclk_high_width_wrong"}, bad_width, 0);
    check({nm, " rise_with_ss_high"}, ss_hi, 0);
    check({nm, " rx_data_held"}, int'(rx_data), int'(v.exp_rx));
  endtask

  initial begin
    int c, rises, nrv, gap, ngap, ss_run, rv_after;
    logic prev_sclk, prev_ss, seen_low;
    logic [7:0] d1, d2;
    total = 0; bad = 0;
    loop_mode = 1'b1; sub_word = '0; rcnt = 0;
    tx_data = '0; tx_valid = 1'b0; clk_div = '0;

    vecs[0] = '{tx: 8'hA5, div: 8'd0,   loop: 1'b1, sub: 8'h00, chg: 1'b0, div2: 8'd0, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hFF, div: 8'd4,   loop: 1'b0, sub: 8'h3C, chg: 1'b0, div2: 8'd0, exp_rx: 8'h3C};
    vecs[2] = '{tx: 8'h00, div: 8'd2,   loop: 1'b0, sub: 8'h96, chg: 1'b0, div2: 8'd0, exp_rx: 8'h96};
    vecs[3] = '{tx: 8'h6E, div: 8'd1,   loop: 1'b1, sub: 8'h00, chg: 1'b1, div2: 8'd7, exp_rx: 8'h6E};
    vecs[4] = '{tx: 8'h01, div: 8'd7,   loop: 1'b0, sub: 8'h5A, chg: 1'b0, div2: 8'd0, exp_rx: 8'h5A};
    vecs[5] = '{tx: 8'h5A, div: 8'd255, loop: 1'b1, sub: 8'h00, chg: 1'b0, div2: 8'd0, exp_rx: 8'h5A};

    // Reset state.
    presetn = 1'b0;
    #1;
    check("rst ss", int'(ss), 1);
    check("rst sclk", int'(sclk), 0);
    check("rst mosi", int'(mosi), 0);
    check("rst rx_data", int'(rx_data), 0);
    check("rst rx_valid", int'(rx_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst tx_ready", int'(tx_ready), 1);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    for (int i = 0; i < 6; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // Async reset mid-SHIFT (D=3, after 3 rising edges).
    loop_mode = 1'b1; rcnt = 0;
    tx_data = 8'hC3; clk_div = 8'd3; tx_valid = 1'b1;
    @(negedge pclk);
    tx_valid = 1'b0;
    rises = 0; prev_sclk = 1'b0; c = 0;
    while (rises < 3 && c < 500) begin
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
      if (rises < 3) begin
        @(negedge pclk);
        c++;
      end
    end
    check("midrst reached_bit3", rises, 3);
    #2 presetn = 1'b0;
    #1;
    check("midrst ss", int'(ss), 1);
    check("midrst sclk", int'(sclk), 0);
    check("midrst mosi", int'(mosi), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst tx_ready", int'(tx_ready), 1);
    check("midrst rx_valid", int'(rx_valid), 0);
    @(negedge pclk);
    presetn = 1'b1;
    rv_after = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge pclk);
      if (rx_valid) rv_after++;
    end
    check("midrst no_rx_valid", rv_after, 0);
    run_xfer(vecs[0], "post_rst");

    // Back-to-back with tx_valid held high.
    loop_mode = 1'b1; rcnt = 0;
    clk_div = 8'd0; tx_data = 8'h01; tx_valid = 1'b1;
    nrv = 0; ngap = 0; gap = 0; ss_run = 0; seen_low = 1'b0; prev_ss = 1'b1;
    d1 = '0; d2 = '0;
    for (c = 0; c < 200 && nrv < 2; c++) begin
      @(negedge pclk);
      if (c == 3) tx_data = 8'h80;
      if (ss) ss_run++;
      if (!ss && prev_ss && seen_low) begin
        gap = ss_run;
        ngap++;
      end
      if (!ss) begin
        seen_low = 1'b1;
        ss_run = 0;
      end
      prev_ss = ss;
      if (rx_valid) begin
        nrv++;
        if (nrv == 1) d1 = rx_data;
        else begin
          d2 = rx_data;
          tx_valid = 1'b0;
        end
      end
    end
    check("b2b rx_valid_pulses", nrv, 2);
    check("b2b first_data", int'(d1), 8'h01);
    check("b2b second_data", int'(d2), 8'h80);
    check("b2b gap_count", ngap, 1);
    check("b2b ss_gap_ge2", int'(gap >= 2), 1);
    c = 0;
    while (!tx_ready && c < 100) begin
      @(negedge pclk);
      c++;
    end
    check("b2b idle_again", int'(tx_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/main_shift_ctrl_block.md
Name: main_shift_ctrl_block

Overview:
- SPI main-side transfer engine; the controller-end counterpart of the sub-side shift register block.
- Takes one parallel byte from the main TX FIFO through a valid/ready handshake, then generates ss/sclk.
- Shifts the byte out on mosi while capturing miso into a parallel RX word, and reports completion with a one-cycle rx_valid pulse.
- Fixed SPI mode 0 (CPOL=0, CPHA=0), MSB first by default.

Parameters:
- DATA_WIDTH, 8, bits per transfer (N); must be ≥2.
- DIV_WIDTH, 8, width of the sclk half-period divider input.

Ports:
- pclk  in  1  system clock.
- presetn  in  1  asynchronous active-low reset.
- clk_div  in  DIV_WIDTH  sclk half-period minus one (D); half-period = D+1 pclk cycles.
- tx_data  in  DATA_WIDTH  byte to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  block can accept a transfer (high only in IDLE).
- rx_data  out  DATA_WIDTH  last received word; holds until the next completion.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  high in any state other than IDLE.
- ss_pad_o  out  1  active-low sub select.
- sclk_pad_o  out  1  serial clock; idles low.
- mosi_pad_o  out  1  serial data to sub.
- miso_pad_i  in  1  serial data from sub; sampled directly, no synchroniser inside.

Behaviour:
- Reset values:
  - ss_pad_o=1, sclk_pad_o=0, mosi_pad_o=0.
  - rx_data=0, rx_valid=0, busy=0, tx_ready=1.
  - State IDLE; counters and shift registers 0.
- Handshake:
  - Transfer is accepted on the pclk edge where tx_valid && tx_ready.
  - tx_data and clk_div are latched at acceptance; later changes on either are ignored until the next IDLE.
- FSM states:
  - IDLE:
    - ss=1, sclk=0.
    - On acceptance go to SETUP: load TX shift register, drive mosi=tx_data[N-1], clear the bit counter.
  - SETUP:
    - ss=0, sclk=0; lasts D+1 cycles, then SHIFT with sclk going high.
  - SHIFT:
    - sclk toggles every D+1 cycles.
    - On each rising transition, sample miso_pad_i into the RX shift register LSB, shifting left.
    - On each falling transition that is not the last, shift TX left and drive the next bit on mosi.
    - The bit counter increments on each rising transition.
    - After the Nth falling transition (sclk low), go to DONE.
  - DONE:
    - ss=1, sclk=0, mosi=0.
    - On entry, rx_data <= RX shift register and rx_valid=1 for exactly that one cycle.
    - Lasts D+1 cycles, then IDLE.
- Latency: accept at cycle T0 → tx_ready high again at T0+1+(2N+2)(D+1). For N=8, D=0 this is T0+19; rx_valid at T0+18.
- Divider:
  - Half-period counter runs 0..D and wraps to 0 on each phase event.
  - D=0 gives sclk = pclk/2.
  - D=2^DIV_WIDTH−1 is legal with no overflow; the counter is DIV_WIDTH bits.
- Back-to-back: tx_valid held high with new data starts the next transfer in the IDLE cycle, so ss stays high for at least D+1+1 cycles between frames.
- Async reset mid-transfer: all outputs return to reset values immediately; no rx_valid; the partial frame is discarded.
- tx_valid during a transfer has no effect (tx_ready=0).

Optional Feature:
- Macro: SPI_MAIN_LSB_FIRST_EN.
- Defined:
  - TX shifts right and drives tx_data[0] first.
  - RX shifts right, inserting miso at bit N-1, so rx_data[0] is the first received bit.
- Undefined: MSB first as described above. Timing is identical in both cases.

Decomposition:
- spi_pkg holds:
  - main_state_e enum {IDLE, SETUP, SHIFT, DONE};
  - SPI_CPOL=0 and SPI_CPHA=0 localparams;
  - the DATA_WIDTH default constant.
- Sub-module spi_sclk_gen:
  - half-period counter plus sclk toggle;
  - outputs rise_evt/fall_evt pulses with an enable input.
- TX and RX serial paths use the existing universal_shift_reg (parallel load / shift modes).

Test Plan:
- Reset mid-SHIFT (D=3, after 3 bits) → ss=1, sclk=0, mosi=0, busy=0, tx_ready=1 at once; no rx_valid; next transfer behaves normally.
- Loopback (miso tied to mosi), D=0, tx_data=8'hA5 → mosi sequence 1,0,1,0,0,1,0,1; rx_data=8'hA5; rx_valid one cycle at T0+18; tx_ready high at T0+19.
- Sub model returns 8'h3C, D=4, tx_data=8'hFF → sclk high/low each 5 cycles; exactly 8 rising edges while ss=0; rx_data=8'h3C.
- Back-to-back with tx_valid held: 8'h01 then 8'h80 → two frames; ss high ≥2 cycles between them; two rx_valid pulses; second tx_data latched only at the second acceptance.
- clk_div changed from 1 to 7 mid-frame → current frame keeps half-period 2; next frame uses 8.
- With SPI_MAIN_LSB_FIRST_EN in loopback, tx_data=8'h01 → first mosi bit 1, remaining 0; rx_data=8'h01.
